bram_shadow_checker: RTL

Synthesisable, parametrised read-data checker for simple-dual-port BRAM inferences. It generalises the single-address gold/gate miter into a self-contained checker. It tracks `NUM_TRK` probe addresses in a shadow model, supports configurable read latency and optional byte-enable writes, and flags any DUT read of a written, tracked address that returns wrong data. It sits beside the RAM under test, either in formal harnesses (probe addresses tied to anyconst) or in simulation benches.

---
 rtl/bram_chk_pkg.sv | 22 ++
 rtl/bram_chk_slot.sv | 52 +++++
 rtl/bram_shadow_checker.sv | 110 +++++++++++
 3 files changed

// File: rtl/bram_chk_pkg.sv
// Shared helpers for the BRAM shadow checker: slot-index width and saturating counters.
// Optional byte-enable shadow updates are selected with the BRAM_CHK_BYTE_WE_EN macro.
package bram_chk_pkg;

  localparam int MAX_TRK   = 16;
  localparam int MAX_LAT   = 4;
  localparam int CNT_MAX_W = 64;

  // Width of a slot index; never zero, even for a single tracked address.
  function automatic int slot_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Increment v, holding at all-ones of a w-bit counter (w <= CNT_MAX_W).
  function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] v,
                                                   input int w);
    logic [CNT_MAX_W-1:0] top;
    top = (w >= CNT_MAX_W) ? '1 : ((CNT_MAX_W'(1) << w) - CNT_MAX_W'(1));
    return (v == top) ? v : v + CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/bram_chk_slot.sv
// One tracked probe address: valid bit plus shadow copy of the last data written there.
// With BRAM_CHK_BYTE_WE_EN defined only the enabled bytes of a write are taken.
module bram_chk_slot
  import bram_chk_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   addr,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [DW-1:0]   wd,
  input  logic [DW/8-1:0] wbe,
  output logic            vld,
  output logic [DW-1:0]   shadow
);

  logic          hit;
  logic [DW-1:0] bmask;

  assign hit = we && (wa == addr);

`ifdef BRAM_CHK_BYTE_WE_EN
  if (DW % 8 != 0) begin : g_dw_check
    $error("bram_chk_slot: DW must be a multiple of 8 with byte enables");
  end

  always_comb begin
    bmask = '0;
    for (int b = 0; b < DW / 8; b++) bmask[b*8 +: 8] = {8{wbe[b]}};
  end
`else
  logic unused_wbe;
  assign unused_wbe = ^wbe;
  assign bmask      = '1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= 1'b0;
      // NOTE: the shadow is reset, not left undefined: bytes never written by a
      // partial write must read back as zero.
      shadow <= '0;
    end else if (hit) begin
      vld    <= 1'b1;
      shadow <= (shadow & ~bmask) | (wd & bmask);
    end
  end

endmodule

// File: rtl/bram_shadow_checker.sv
// Read-data checker for a simple-dual-port BRAM: shadows NUM_TRK probe addresses and
// flags wrong read data after RD_LAT cycles. Byte enables need BRAM_CHK_BYTE_WE_EN.
module bram_shadow_checker
  import bram_chk_pkg::*;
#(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int NUM_TRK = 4,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_TRK*AW-1:0]           trk_addr,
  input  logic                            we,
  input  logic [AW-1:0]                   wa,
  input  logic [DW-1:0]                   wd,
  input  logic [DW/8-1:0]                 wbe,
  input  logic [AW-1:0]                   ra,
  input  logic [DW-1:0]                   rd,
  output logic                            err,
  output logic [slot_w(NUM_TRK)-1:0]      err_slot,
  output logic [CNT_W-1:0]                err_cnt,
  output logic [CNT_W-1:0]                chk_cnt
);

  localparam int SW = slot_w(NUM_TRK);

  if (NUM_TRK < 1 || NUM_TRK > MAX_TRK) begin : g_trk_check
    $error("bram_shadow_checker: NUM_TRK out of range");
  end
  if (RD_LAT < 1 || RD_LAT > MAX_LAT) begin : g_lat_check
    $error("bram_shadow_checker: RD_LAT out of range");
  end

  typedef struct packed {
    logic          vld;
    logic [SW-1:0] slot;
    logic [DW-1:0] expect_data;
  } chk_entry_t;

  logic [NUM_TRK-1:0] vld;
  logic [DW-1:0]      shadow [NUM_TRK];

  for (genvar i = 0; i < NUM_TRK; i++) begin : g_slot
    bram_chk_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .addr   (trk_addr[i*AW +: AW]),
      .we     (we),
      .wa     (wa),
      .wd     (wd),
      .wbe    (wbe),
      .vld    (vld[i]),
      .shadow (shadow[i])
    );
  end

  logic          hit;
  logic [SW-1:0] hit_slot;
  logic [DW-1:0] hit_data;
  logic          issue;

  // Scan from the top down so the lowest matching slot is the one that sticks.
  always_comb begin
    // NOTE: defaults first so no path through the loop leaves these unassigned.
    hit      = 1'b0;
    hit_slot = '0;
    hit_data = '0;
    for (int i = NUM_TRK - 1; i >= 0; i--) begin
      if (vld[i] && (trk_addr[i*AW +: AW] == ra)) begin
        hit      = 1'b1;
        hit_slot = SW'(i);
        hit_data = shadow[i];
      end
    end
  end

  // Read-during-write to the same address has undefined data and is skipped.
  assign issue = hit && !(we && (wa == ra));

  chk_entry_t pipe [RD_LAT];
  chk_entry_t last;

  assign last = pipe[RD_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) pipe[k] <= '0;
      err      <= 1'b0;
      err_slot <= '0;
      err_cnt  <= '0;
      chk_cnt  <= '0;
    end else begin
      pipe[0] <= '{vld: issue, slot: hit_slot, expect_data: hit_data};
      for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
      if (last.vld) begin
        chk_cnt <= CNT_W'(sat_inc(CNT_MAX_W'(chk_cnt), CNT_W));
        if (rd != last.expect_data) begin
          err_cnt <= CNT_W'(sat_inc(CNT_MAX_W'(err_cnt), CNT_W));
          if (!err) begin
            err      <= 1'b1;
            err_slot <= last.slot;
          end
        end
      end
    end
  end

endmodule
